// File: rtl/mem_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// mem_lsu_ctrl
// ---------------------------------------------------------------------------
// Memory-stage load/store controller. Takes the operation held in the
// EXU->MEM pipeline register, issues exactly one request per memory op to the
// data memory port, waits for the response and returns the lane-aligned,
// sign/zero-extended load result. While an access is outstanding mem_stall
// holds the pipeline register (and everything upstream) in place.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : half/word/dword accesses that are not naturally aligned issue
//               no request; the FSM goes straight to DONE and pulses the extra
//               output misalign_fault for one cycle (load_done stays 0).
//   undefined : no alignment check, no misalign_fault port; byte masks that
//               would cross the 8-byte line are simply truncated.
//
// Parameters
//   ADDR_WIDTH  byte address width (default 64)
//   DATA_WIDTH  memory port data width, fixed at 64 (8 byte lanes)
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   valid                 MEM-stage instruction is valid
//   is_load / is_store    operation type (both set is treated as a store)
//   is_unsigned           zero-extend the load result
//   ls_size               one-hot size [0]=B [1]=H [2]=W [3]=D, else dword
//   ls_address            effective byte address
//   store_data            right-aligned store value
//   flush                 kill the current access (pipeline redirect)
//   req_valid/req_ready   memory request handshake
//   req_write             1 = store, 0 = load
//   req_addr              8-byte aligned request address
//   req_wdata             store data moved onto its byte lanes
//   req_wmask             byte-enable mask for the accessed lanes
//   resp_valid/resp_rdata memory response (read data or write ack)
//   mem_stall             hold the EXU->MEM register and upstream
//   opload_read_data_wb   extended load result
//   load_done             one-cycle pulse, opload_read_data_wb is new
//   misalign_fault        (MEM_MISALIGN_CHECK_EN only) one-cycle fault pulse
// ---------------------------------------------------------------------------
module mem_lsu_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_unsigned,
  input  logic [3:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_address,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  flush,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic [7:0]            req_wmask,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_stall,
  output logic [DATA_WIDTH-1:0] opload_read_data_wb,
  output logic                  load_done
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                  misalign_fault
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // FSM state and the per-operation context captured at accept time
  state_e                  state_q, state_d;
  logic                    kill_q, kill_d;
  logic                    op_load_q, op_load_d;
  logic                    op_unsigned_q, op_unsigned_d;
  size_e                   op_size_q, op_size_d;
  logic [2:0]              op_offset_q, op_offset_d;

  // Registered request and result outputs
  logic                    req_valid_q, req_valid_d;
  logic                    req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic [7:0]              req_wmask_q, req_wmask_d;
  logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
  logic                    load_done_q, load_done_d;
`ifdef MEM_MISALIGN_CHECK_EN
  logic                    misalign_fault_q, misalign_fault_d;
  logic                    in_misaligned;
`endif

  // Decoded view of the operation currently presented by the pipeline
  logic                    accept;
  size_e                   in_size;
  logic [2:0]              in_offset;
  logic [7:0]              in_base_mask;
  logic [7:0]              in_wmask;
  logic [DATA_WIDTH-1:0]   in_wdata;

  // Response lane extraction
  logic [DATA_WIDTH-1:0]   rdata_shifted;
  logic                    ext_bit;
  logic [DATA_WIDTH-1:0]   load_ext;

  assign accept    = valid & (is_load | is_store) & ~flush;
  assign in_offset = ls_address[2:0];

  // Anything that is not exactly one-hot falls back to a dword access
  always_comb begin
    in_size = SZ_D;
    case (ls_size)
      4'b0001: in_size = SZ_B;
      4'b0010: in_size = SZ_H;
      4'b0100: in_size = SZ_W;
      default: in_size = SZ_D;
    endcase
  end

  always_comb begin
    in_base_mask = 8'hFF;
    case (in_size)
      SZ_B:    in_base_mask = 8'h01;
      SZ_H:    in_base_mask = 8'h03;
      SZ_W:    in_base_mask = 8'h0F;
      default: in_base_mask = 8'hFF;
    endcase
  end

  // Shifting in an 8-bit / 64-bit context drops lanes past the line end
  assign in_wmask = in_base_mask << in_offset;
  assign in_wdata = store_data << {in_offset, 3'b000};

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    in_misaligned = 1'b0;
    case (in_size)
      SZ_H:    in_misaligned = in_offset[0];
      SZ_W:    in_misaligned = |in_offset[1:0];
      SZ_D:    in_misaligned = |in_offset;
      default: in_misaligned = 1'b0;
    endcase
  end
`endif

  // Bring the addressed byte down to lane 0, then truncate and extend
  assign rdata_shifted = resp_rdata >> {op_offset_q, 3'b000};

  always_comb begin
    ext_bit  = 1'b0;
    load_ext = rdata_shifted;
    case (op_size_q)
      SZ_B: begin
        ext_bit  = ~op_unsigned_q & rdata_shifted[7];
        load_ext = {{(DATA_WIDTH-8){ext_bit}}, rdata_shifted[7:0]};
      end
      SZ_H: begin
        ext_bit  = ~op_unsigned_q & rdata_shifted[15];
        load_ext = {{(DATA_WIDTH-16){ext_bit}}, rdata_shifted[15:0]};
      end
      SZ_W: begin
        ext_bit  = ~op_unsigned_q & rdata_shifted[31];
        load_ext = {{(DATA_WIDTH-32){ext_bit}}, rdata_shifted[31:0]};
      end
      default: begin
        ext_bit  = 1'b0;
        load_ext = rdata_shifted;
      end
    endcase
  end

  // The stall must rise in the accept cycle itself so the pipeline register
  // does not advance past the op; it drops in DONE so the op retires there.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE:  mem_stall = accept;
      S_REQ:   mem_stall = 1'b1;
      S_WAIT:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Next-state logic. A flush that lands in the same cycle as the request
  // handshake cannot recall the request, so it turns into a drain in WAIT.
  // kill_q marks a WAIT whose response must be swallowed silently.
  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    op_load_d     = op_load_q;
    op_unsigned_d = op_unsigned_q;
    op_size_d     = op_size_q;
    op_offset_d   = op_offset_q;
    req_valid_d   = req_valid_q;
    req_write_d   = req_write_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    req_wmask_d   = req_wmask_q;
    load_data_d   = load_data_q;
    load_done_d   = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_fault_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_load_d     = is_load & ~is_store;
          op_unsigned_d = is_unsigned;
          op_size_d     = in_size;
          op_offset_d   = in_offset;
          kill_d        = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
          if (in_misaligned) begin
            state_d          = S_DONE;
            misalign_fault_d = 1'b1;
          end else
`endif
          begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_write_d = is_store;
            req_addr_d  = {ls_address[ADDR_WIDTH-1:3], 3'b000};
            req_wdata_d = in_wdata;
            req_wmask_d = in_wmask;
          end
        end
      end

      S_REQ: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
          kill_d      = flush;
        end else if (flush) begin
          req_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_WAIT: begin
        if (resp_valid) begin
          kill_d = 1'b0;
          if (kill_q | flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (op_load_q) begin
              load_data_d = load_ext;
              load_done_d = 1'b1;
            end
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Single state register; reset clears everything, including any knowledge
  // of a response still in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      kill_q        <= 1'b0;
      op_load_q     <= 1'b0;
      op_unsigned_q <= 1'b0;
      op_size_q     <= SZ_B;
      op_offset_q   <= 3'd0;
      req_valid_q   <= 1'b0;
      req_write_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_wmask_q   <= 8'h00;
      load_data_q   <= '0;
      load_done_q   <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_fault_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      op_load_q     <= op_load_d;
      op_unsigned_q <= op_unsigned_d;
      op_size_q     <= op_size_d;
      op_offset_q   <= op_offset_d;
      req_valid_q   <= req_valid_d;
      req_write_q   <= req_write_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      req_wmask_q   <= req_wmask_d;
      load_data_q   <= load_data_d;
      load_done_q   <= load_done_d;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_fault_q <= misalign_fault_d;
`endif
    end
  end

  assign req_valid           = req_valid_q;
  assign req_write           = req_write_q;
  assign req_addr            = req_addr_q;
  assign req_wdata           = req_wdata_q;
  assign req_wmask           = req_wmask_q;
  assign opload_read_data_wb = load_data_q;
  assign load_done           = load_done_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_fault      = misalign_fault_q;
`endif

endmodule
